// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/response plus the decode-side
// view (held instruction, pc, retire controls) and the sticky fetch error.
// master = fetch stage (drives requests and the held instruction); slave = memory/decode side.
interface instr_fetch_if;
  // instruction memory
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  // decode side
  logic [31:0] instr;
  logic [10:0] opcode;
  logic        instr_valid;
  logic [63:0] pc;
  logic        stall;
  logic        branch;
  logic        uncond_branch;
  logic        zero;
  logic [63:0] branch_offset;
  // status
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, fetch_err,
    input  imem_ready, imem_rdata, stall, branch, uncond_branch, zero, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, fetch_err,
    output imem_ready, imem_rdata, stall, branch, uncond_branch, zero, branch_offset
  );
endinterface

// File: rtl/instr_fetch.sv
// LEGv8 instruction fetch: owns the PC, fetches a word per instruction, holds it for decode.
// Latency: 2 cycles per instruction minimum (FETCH with same-cycle ready, then DECODE).
// Backpressure: stall holds DECODE; a memory that never answers within TIMEOUT edges
// parks the stage in a sticky error until reset.
// Ports: clk, reset (async, active-high), bus (instr_fetch_if.master). All outputs are
// decoded from registers only.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  // Counter only has to reach TIMEOUT-1; keep it at least one bit wide.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_pc;
  logic [31:0]   r_instr;

  logic          w_cnt_last;
  logic          w_accept;
  logic          w_retire;
  logic          w_taken;
  logic [63:0]   w_next_pc;

  assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));
  assign w_accept   = (r_state == S_FETCH) && bus.imem_ready;
  assign w_retire   = (r_state == S_DECODE) && !bus.stall;

  // Branch controls are only consumed under w_retire, so X on them outside a
  // retire edge never reaches state.
  assign w_taken    = bus.uncond_branch | (bus.branch & bus.zero);
  assign w_next_pc  = w_taken ? (r_pc + (bus.branch_offset << 2)) : (r_pc + 64'd4);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt     = r_state;
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    bus.fetch_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        // Ready on the last allowed edge still wins over the timeout.
        if (bus.imem_ready) begin
          w_state_nxt = S_DECODE;
        end else if (w_cnt_last) begin
          w_state_nxt = S_ERR;
        end
      end
      S_DECODE: begin
        bus.instr_valid = 1'b1;
        if (!bus.stall) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_ERR: begin
        bus.fetch_err = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: PC, held instruction, miss counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_instr <= bus.imem_rdata;
        r_cnt   <= '0;
      end else if ((r_state == S_FETCH) && !w_cnt_last) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_retire) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.pc        = r_pc;
  assign bus.instr     = r_instr;
  assign bus.opcode    = r_instr[31:21];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then randomized
// traffic, all compared every negedge against a transaction-level model of the stage.
module tb_instr_fetch;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] junk = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(64'h0), .TIMEOUT(TO)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory image: address 0 holds an ADD, the rest a scramble of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B020020;
    return (a[33:2] * 32'h9E3779B1 + 32'h01357BDF) ^ a[63:32];
  endfunction

  // Data bus only carries the real word while ready is asserted.
  assign bus.imem_rdata = bus.imem_ready ? mem_word(bus.imem_addr) : junk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes: 0 = waiting one cycle after reset, 1 = requesting a word,
  // 2 = holding a word for decode, 3 = dead (memory timed out).
  int          m_mode  = 0;
  int          m_miss  = 0;
  logic [63:0] m_pc    = 64'h0;
  logic [31:0] m_instr = 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode  = 0;
      m_miss  = 0;
      m_pc    = 64'h0;
      m_instr = 32'h0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          if (bus.imem_ready === 1'b1) begin
            m_instr = mem_word(m_pc);
            m_miss  = 0;
            m_mode  = 2;
          end else begin
            m_miss = m_miss + 1;
            if (m_miss >= TO) m_mode = 3;
          end
        end
        2: begin
          if (bus.stall === 1'b0) begin
            if (bus.uncond_branch || (bus.branch && bus.zero))
              m_pc = m_pc + bus.branch_offset * 4;
            else
              m_pc = m_pc + 4;
            m_mode = 1;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("imem_req",    bus.imem_req,    64'(m_mode == 1));
    check("instr_valid", bus.instr_valid, 64'(m_mode == 2));
    check("fetch_err",   bus.fetch_err,   64'(m_mode == 3));
    check("imem_addr",   bus.imem_addr,   m_pc);
    check("pc",          bus.pc,          m_pc);
    check("instr",       bus.instr,       m_instr);
    check("opcode",      bus.opcode,      m_instr[31:21]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic defaults;
    bus.imem_ready    = 1'b1;
    bus.stall         = 1'b0;
    bus.branch        = 1'b0;
    bus.uncond_branch = 1'b0;
    bus.zero          = 1'b0;
    bus.branch_offset = 64'h0;
  endtask

  // Leaves reset released at posedge+1; the next edge is the IDLE->FETCH edge.
  task automatic do_reset;
    @(posedge clk);
    #3;
    reset = 1'b1;
    defaults();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_to(input logic [63:0] a);
    int k = 0;
    while (!(bus.instr_valid === 1'b1 && bus.pc === a) && k < 64) begin
      tick();
      k++;
    end
    check("run_to_reached", 64'(k < 64), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    defaults();
    reset = 1'b1;
    tick();
    tick();
    // Reset values
    check("rst_imem_req",    bus.imem_req,    64'h0);
    check("rst_instr_valid", bus.instr_valid, 64'h0);
    check("rst_fetch_err",   bus.fetch_err,   64'h0);
    check("rst_opcode",      bus.opcode,      64'h0);
    check("rst_pc",          bus.pc,          64'h0);
    reset = 1'b0;

    // One idle cycle, then sequential addresses 0,4,8,12
    check("idle_after_reset", bus.imem_req, 64'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("seq_req",  bus.imem_req,  64'h1);
      check("seq_addr", bus.imem_addr, 64'(k * 4));
      tick();
      check("seq_valid", bus.instr_valid, 64'h1);
      if (k == 0) begin
        check("add_instr",  bus.instr,  64'h8B020020);
        check("add_opcode", bus.opcode, 64'b10001011000);
      end
    end

    // Unconditional branch back by 2 words from 0x10
    run_to(64'h10);
    bus.uncond_branch = 1'b1;
    bus.branch_offset = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    check("b_back_addr", bus.imem_addr, 64'h08);
    defaults();

    // Unconditional branch forward by 3 words from 0x10
    run_to(64'h10);
    bus.uncond_branch = 1'b1;
    bus.branch_offset = 64'd3;
    tick();
    check("b_fwd_addr", bus.imem_addr, 64'h1C);
    defaults();

    // CBZ not taken
    run_to(64'h20);
    bus.branch = 1'b1;
    bus.zero = 1'b0;
    bus.branch_offset = 64'd5;
    tick();
    check("cbz_nt_addr", bus.imem_addr, 64'h24);
    defaults();

    // CBZ taken
    do_reset();
    run_to(64'h20);
    bus.branch = 1'b1;
    bus.zero = 1'b1;
    bus.branch_offset = 64'd5;
    tick();
    check("cbz_t_addr", bus.imem_addr, 64'h34);
    defaults();

    // Stall hold for 5 cycles while branch/zero toggle
    run_to(64'h34);
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.branch = 1'($urandom_range(1));
      bus.zero = ~bus.zero;
      bus.branch_offset = 64'd1;
      tick();
      check("stall_valid", bus.instr_valid, 64'h1);
      check("stall_pc",    bus.pc,          64'h34);
      check("stall_instr", bus.instr,       64'(mem_word(64'h34)));
    end
    bus.stall = 1'b0;
    bus.branch = 1'b1;
    bus.zero = 1'b1;
    bus.branch_offset = 64'hFFFF_FFFF_FFFF_FFFD;
    tick();
    check("release_req",  bus.imem_req,  64'h1);
    check("release_addr", bus.imem_addr, 64'h28);
    defaults();
    tick();
    check("release_one_update", bus.pc, 64'h28);
    check("release_valid",      bus.instr_valid, 64'h1);

    // Ready arrives on the 4th FETCH edge: normal decode
    do_reset();
    bus.imem_ready = 1'b0;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("wait_req", bus.imem_req,  64'h1);
      check("wait_err", bus.fetch_err, 64'h0);
    end
    bus.imem_ready = 1'b1;
    tick();
    check("late_ready_valid", bus.instr_valid, 64'h1);
    check("late_ready_err",   bus.fetch_err,   64'h0);

    // Ready never arrives: error after 4 edges
    bus.imem_ready = 1'b0;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("to_pre_err", bus.fetch_err, 64'h0);
    end
    tick();
    check("to_err",   bus.fetch_err,   64'h1);
    check("to_req",   bus.imem_req,    64'h0);
    check("to_valid", bus.instr_valid, 64'h0);
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("err_sticky", bus.fetch_err, 64'h1);
      check("err_no_req", bus.imem_req,  64'h0);
    end
    do_reset();
    check("err_cleared", bus.fetch_err, 64'h0);
    tick();
    check("restart_addr", bus.imem_addr, 64'h0);
    check("restart_req",  bus.imem_req,  64'h1);

    // Wrap: 0 - 4 then +4 back to 0
    tick();
    bus.uncond_branch = 1'b1;
    bus.branch_offset = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    check("neg_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    defaults();
    tick();
    tick();
    check("wrap_addr", bus.imem_addr, 64'h0);

    // Async reset mid-DECODE
    run_to(64'h8);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", bus.instr_valid, 64'h0);
    check("async_pc",    bus.pc,          64'h0);
    check("async_req",   bus.imem_req,    64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 300 == 0) do_reset();
      bus.imem_ready    = ($urandom_range(3) != 0);
      bus.stall         = ($urandom_range(2) == 0);
      bus.branch        = 1'($urandom_range(1));
      bus.uncond_branch = ($urandom_range(3) == 0);
      bus.zero          = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) begin
        bus.branch_offset = {$urandom, $urandom};
      end else begin
        longint ls;
        ls = longint'(int'($urandom_range(32)) - 16);
        bus.branch_offset = ls;
      end
      junk = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the LEGv8 single-cycle datapath, sitting directly upstream of the `control` decoder. It owns the program counter, fetches 32-bit instruction words from instruction memory over a ready handshake, and presents the held instruction and its 11-bit opcode field to decode. It computes the next PC from the branch controls and the ALU zero flag that decode and execute return. A timeout counter converts a hung memory into a sticky error.

## Interface

- `RESET_PC`, 64'h0, PC value loaded on reset
- `TIMEOUT`, 16, max FETCH cycles without `imem_ready` before error (>=1)
- `clk` input 1, single clock, all state on rising edge
- `reset` input 1, asynchronous, active-high
- `imem_req` output 1, fetch request
- `imem_addr` output 64, byte address of requested word (= `pc`)
- `imem_ready` input 1, `imem_rdata` valid this cycle
- `imem_rdata` input 32, instruction word
- `instr` output 32, held instruction
- `opcode` output 11, `instr[31:21]`, feeds `control.opcode`
- `instr_valid` output 1, `instr`/`opcode`/`pc` valid for decode
- `pc` output 64, address of the held instruction
- `stall` input 1, decode/execute not ready to retire `instr`
- `branch` input 1, conditional branch (CBZ) from `control`
- `uncond_branch` input 1, B from `control`
- `zero` input 1, ALU zero flag
- `branch_offset` input 64, sign-extended word offset from the immediate path
- `fetch_err` output 1, sticky timeout error

## Operation

- States: IDLE, FETCH, DECODE, ERR. Reset state is IDLE.
- IDLE: `imem_req`=0. Unconditionally moves to FETCH on the next edge. This gives one idle cycle after reset release.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On an edge with `imem_ready`=1: `instr`<=`imem_rdata`, the timeout counter clears, and the state moves to DECODE.
  - Otherwise the counter increments.
  - When the counter reaches `TIMEOUT`-1 and `imem_ready`=0, the state moves to ERR.
- DECODE:
  - `instr_valid`=1 and `imem_req`=0.
  - On an edge with `stall`=0 (retire): `pc`<=`next_pc` and the state moves to FETCH.
  - With `stall`=1, everything holds.
- ERR: `fetch_err`=1, `imem_req`=0, `instr_valid`=0. Only reset exits ERR.
- `taken` = `uncond_branch` | (`branch` & `zero`). `taken` is evaluated only at the retire edge; the inputs are ignored at all other times.
- `next_pc` = `taken` ? `pc` + (`branch_offset` << 2) : `pc` + 4.
  - Arithmetic is 64-bit two's complement, modulo 2^64; no overflow detection.
  - Bits shifted out of `branch_offset` are discarded.
- `branch` and `uncond_branch` may be X for undecoded opcodes. If `instr_valid`=0 they must not affect state. If both are X at retire, the result is don't-care for verification.
- `pc[1:0]` stays as loaded; with a word-aligned `RESET_PC` it is always 00. Misalignment is not checked.
- `opcode` is a combinational slice of the `instr` register, so it changes only when `instr` is loaded.

## Timing

- Reset values (asynchronous):
  - `pc`=`RESET_PC`, `instr`=32'h0, state IDLE, counter 0.
  - Hence `imem_req`=0, `instr_valid`=0, `fetch_err`=0, `opcode`=11'h0.
- Every output is a function of registers only; there is no input-to-output combinational path.
- Minimum cadence is 2 cycles per instruction, with `imem_ready` returned in the same cycle as `imem_req` and `stall`=0.
- Latency from the retire edge to the next `imem_req` is 0 cycles: FETCH is entered on that edge.
- `imem_ready` is ignored outside FETCH.
- Reset asserted mid-FETCH or mid-DECODE aborts immediately: no retire, `pc` returns to `RESET_PC`.
- Simultaneous `branch`=1 and `uncond_branch`=1 means taken.
- Timeout boundaries:
  - With `TIMEOUT`=N, ERR is entered on the N-th consecutive FETCH edge without `imem_ready`.
  - `imem_ready`=1 on the N-th edge is accepted normally; ERR is not entered.

## Test plan

- **Reset and sequential fetch:** `RESET_PC`=0, memory always ready.
  - Required: `imem_req` is low for 1 cycle after reset release.
  - Required: the address sequence is 0, 4, 8, 12 with `stall`=0.
  - Required: `opcode` = `instr[31:21]`; for word 0x8B020020 (ADD), `opcode` = 11'b10001011000.
- **Unconditional branch:**
  - At `pc`=0x10: `uncond_branch`=1, `branch_offset`=-2 → next `imem_addr`=0x08.
  - At `pc`=0x10: `branch_offset`=3 → next `imem_addr`=0x1C.
- **CBZ:**
  - At `pc`=0x20: `branch`=1, `zero`=0, `branch_offset`=5 → next `imem_addr`=0x24.
  - Repeat with `zero`=1 → next `imem_addr`=0x34.
- **Stall hold:**
  - Hold `stall`=1 for 5 cycles in DECODE while toggling `zero` and `branch` → `instr`, `pc` and `instr_valid` are unchanged.
  - On release, exactly one PC update occurs, using the inputs present at the release edge.
- **Memory wait and timeout**, with `TIMEOUT`=4:
  - Ready arriving on the 4th FETCH cycle → normal DECODE.
  - Ready never arriving → `fetch_err`=1 after 4 cycles and `imem_req`=0 thereafter.
  - Reset clears the error and fetch restarts at `RESET_PC`.
- **Wrap and async reset:**
  - At `pc`=64'hFFFF_FFFF_FFFF_FFFC with no branch → next `pc`=0.
  - Asserting `reset` mid-cycle in DECODE forces `instr_valid`=0 before the next clock edge.
